// File: rtl/fpalu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpalu_pkg
// Description : Shared encodings for the FP add/mul scheduler.
// Revision    : 1.0
// ============================================================================
package fpalu_pkg;

    localparam int FP_W = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_EXEC = S_EXEC,
        ST_RESP = S_RESP
    } state_e;

endpackage
`default_nettype wire

// File: rtl/fpalu_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fpalu_rr_arb
// Description : Combinational 2-way round-robin arbiter; history kept by parent.
// Revision    : 1.0
// ============================================================================
module fpalu_rr_arb (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // On a tie the requester that was not served last wins.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fpalu_sched.sv
`default_nettype none
// ============================================================================
// Module      : fpalu_sched
// Description : Two-client scheduler for one shared FP add/mul datapath.
// Revision    : 1.0
// ============================================================================
module fpalu_sched
    import fpalu_pkg::*;
#(
    parameter int LAT = 2,
    parameter int CW  = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [FP_W-1:0] req0_a,
    input  logic [FP_W-1:0] req0_b,
    input  logic            req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [FP_W-1:0] req1_a,
    input  logic [FP_W-1:0] req1_b,
    input  logic            req1_op,
    output logic [FP_W-1:0] alu_a,
    output logic [FP_W-1:0] alu_b,
    output logic            alu_op,
    input  logic [FP_W-1:0] alu_result,
    input  logic            alu_overflow,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [FP_W-1:0] rsp_result,
    output logic            rsp_overflow,
    output logic            busy
);

    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;
    logic [FP_W-1:0] alu_a_q, alu_a_d;
    logic [FP_W-1:0] alu_b_q, alu_b_d;
    logic            alu_op_q, alu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [FP_W-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_overflow_q, rsp_overflow_d;

    logic [1:0]      grant;
    logic [1:0]      hs;

    fpalu_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Grant is only exposed while idle; grant already implies valid.
    assign hs         = (state_q == ST_IDLE) ? grant : 2'b00;
    assign req0_ready = hs[0];
    assign req1_ready = hs[1];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_op_d       = alu_op_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (hs != 2'b00) begin
                    alu_a_d      = hs[1] ? req1_a  : req0_a;
                    alu_b_d      = hs[1] ? req1_b  : req0_b;
                    alu_op_d     = hs[1] ? req1_op : req0_op;
                    rsp_id_d     = hs[1];
                    last_grant_d = hs[1];
                    cnt_d        = '0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_result_d   = alu_result;
                    rsp_overflow_d = alu_overflow;
                    rsp_valid_d    = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            last_grant_q   <= 1'b1;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_op_q       <= alu_op_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign busy         = (state_q != ST_IDLE);

endmodule
`default_nettype wire
